// File: rtl/split_target_port_gen2.sv
// Serial-bus target port: deserialises commands, serialises FIFO read data.
// Optional receive/transmit even parity with `define SPLIT_TARGET_PARITY_EN.
module split_target_port_gen2 #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TX_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_data_in,
  input  logic                  bus_data_in_valid,
  input  logic                  bus_mode,
  input  logic                  bus_rw,
  input  logic                  decoder_valid,
  output logic                  bus_data_out,
  output logic                  bus_data_out_valid,
  output logic [ADDR_WIDTH-1:0] target_addr_in,
  output logic [DATA_WIDTH-1:0] target_data_in,
  output logic                  target_cmd_write,
  output logic                  target_cmd_valid,
  input  logic                  target_cmd_ready,
  input  logic [DATA_WIDTH-1:0] target_data_out,
  input  logic                  target_data_out_valid,
  output logic                  target_data_out_ready,
  output logic                  tx_busy,
  output logic                  parity_err,
  input  logic                  split_req,
  input  logic                  arbiter_grant,
  input  logic                  target_split_ack,
  output logic                  arbiter_split_req,
  output logic                  split_grant,
  output logic                  bus_split_ack
);

  localparam int MW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int BW = $clog2(MW);
  localparam int TW = $clog2(DATA_WIDTH);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] R_ADDR = 3'd0;
  localparam logic [2:0] R_DATA = 3'd1;
  localparam logic [2:0] R_HOLD = 3'd2;
`ifdef SPLIT_TARGET_PARITY_EN
  localparam logic [2:0] R_APAR = 3'd3;
  localparam logic [2:0] R_DPAR = 3'd4;
  localparam logic [1:0] T_PAR  = 2'd3;
`endif
  localparam logic [1:0] T_IDLE  = 2'd0;
  localparam logic [1:0] T_LOAD  = 2'd1;
  localparam logic [1:0] T_SHIFT = 2'd2;

  logic [2:0]            state_q, state_d;
  logic [BW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_q, wr_d;
  logic                  bit_ok;
  logic                  last_a, last_d;
`ifdef SPLIT_TARGET_PARITY_EN
  logic                  dec_q, dec_d;
  logic                  rw_q, rw_d;
  logic                  perr_q, perr_d;
  logic                  tpar_q, tpar_d;
`endif

  logic [DATA_WIDTH-1:0] mem_q [TX_DEPTH];
  logic [PW-1:0]         wp_q, wp_d;
  logic [PW-1:0]         rp_q, rp_d;
  logic [CW-1:0]         count_q, count_d;
  logic [1:0]            ts_q, ts_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  ov_q, ov_d;
  logic                  od_q, od_d;
  logic                  push, pop, fifo_ne;

  assign arbiter_split_req = split_req;
  assign split_grant       = arbiter_grant;
  assign bus_split_ack     = target_split_ack;

  assign fifo_ne = (count_q != '0);
  assign tx_busy = fifo_ne || (ts_q != T_IDLE);
  assign target_data_out_ready = (count_q != CW'(TX_DEPTH));
  assign push = target_data_out_valid && target_data_out_ready;

  assign bus_data_out       = od_q;
  assign bus_data_out_valid = ov_q;
  assign target_addr_in     = addr_q;
  assign target_data_in     = data_q;
  assign target_cmd_write   = wr_q;
  assign target_cmd_valid   = (state_q == R_HOLD);
`ifdef SPLIT_TARGET_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  // Half-duplex: the receiver is deaf while read data is pending or moving.
  assign bit_ok = bus_data_in_valid && !tx_busy;
  assign last_a = (cnt_q == BW'(ADDR_WIDTH - 1));
  assign last_d = (cnt_q == BW'(DATA_WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
`ifdef SPLIT_TARGET_PARITY_EN
    dec_d   = dec_q;
    rw_d    = rw_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      R_ADDR: begin
        if (bit_ok && !bus_mode) begin
          for (int i = 0; i < ADDR_WIDTH; i++)
            if (cnt_q == BW'(i)) addr_d[i] = bus_data_in;
          if (last_a) begin
            cnt_d = '0;
`ifdef SPLIT_TARGET_PARITY_EN
            dec_d   = decoder_valid;
            rw_d    = bus_rw;
            state_d = R_APAR;
`else
            if (decoder_valid) begin
              data_d  = '0;
              wr_d    = 1'b0;
              state_d = bus_rw ? R_DATA : R_HOLD;
            end
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef SPLIT_TARGET_PARITY_EN
      R_APAR: begin
        if (bit_ok && !bus_mode) begin
          if (bus_data_in != ^addr_q) begin
            perr_d  = 1'b1;
            state_d = R_ADDR;
          end else if (!dec_q) begin
            state_d = R_ADDR;
          end else begin
            data_d  = '0;
            wr_d    = 1'b0;
            state_d = rw_q ? R_DATA : R_HOLD;
          end
        end
      end
      R_DPAR: begin
        if (bit_ok && bus_mode) begin
          if (bus_data_in != ^data_q) begin
            perr_d  = 1'b1;
            state_d = R_ADDR;
          end else begin
            wr_d    = 1'b1;
            state_d = R_HOLD;
          end
        end
      end
`endif
      R_DATA: begin
        if (bit_ok && bus_mode) begin
          for (int i = 0; i < DATA_WIDTH; i++)
            if (cnt_q == BW'(i)) data_d[i] = bus_data_in;
          if (last_d) begin
            cnt_d = '0;
`ifdef SPLIT_TARGET_PARITY_EN
            state_d = R_DPAR;
`else
            wr_d    = 1'b1;
            state_d = R_HOLD;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (bit_ok) begin
          // Address-mode bit aborts the write and starts a new address.
          addr_d[0] = bus_data_in;
          cnt_d     = BW'(1);
          state_d   = R_ADDR;
        end
      end
      R_HOLD: begin
        if (target_cmd_ready) begin
          cnt_d   = '0;
          state_d = R_ADDR;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = R_ADDR;
      end
    endcase
  end

  always_comb begin
    ts_d   = ts_q;
    sh_d   = sh_q;
    tcnt_d = tcnt_q;
    ov_d   = 1'b0;
    od_d   = 1'b0;
    pop    = 1'b0;
`ifdef SPLIT_TARGET_PARITY_EN
    tpar_d = tpar_q;
`endif
    case (ts_q)
      T_IDLE: begin
        if (fifo_ne) begin
          pop  = 1'b1;
          sh_d = mem_q[rp_q];
          ts_d = T_LOAD;
        end
      end
      T_LOAD: begin
        ov_d   = 1'b1;
        od_d   = sh_q[0];
        sh_d   = sh_q >> 1;
        tcnt_d = '0;
        ts_d   = T_SHIFT;
`ifdef SPLIT_TARGET_PARITY_EN
        tpar_d = ^sh_q;
`endif
      end
      T_SHIFT: begin
        if (tcnt_q == TW'(DATA_WIDTH - 1)) begin
`ifdef SPLIT_TARGET_PARITY_EN
          ov_d = 1'b1;
          od_d = tpar_q;
          ts_d = T_PAR;
`else
          // The next word loads here, giving one idle cycle between words.
          ts_d = T_IDLE;
          if (fifo_ne) begin
            pop  = 1'b1;
            sh_d = mem_q[rp_q];
            ts_d = T_LOAD;
          end
`endif
        end else begin
          ov_d   = 1'b1;
          od_d   = sh_q[0];
          sh_d   = sh_q >> 1;
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: begin
        ts_d = T_IDLE;
        if (fifo_ne) begin
          pop  = 1'b1;
          sh_d = mem_q[rp_q];
          ts_d = T_LOAD;
        end
      end
    endcase
  end

  always_comb begin
    wp_d    = push ? wp_q + 1'b1 : wp_q;
    rp_d    = pop ? rp_q + 1'b1 : rp_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= target_data_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= R_ADDR;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ts_q    <= T_IDLE;
      sh_q    <= '0;
      tcnt_q  <= '0;
      ov_q    <= 1'b0;
      od_q    <= 1'b0;
`ifdef SPLIT_TARGET_PARITY_EN
      dec_q   <= 1'b0;
      rw_q    <= 1'b0;
      perr_q  <= 1'b0;
      tpar_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ts_q    <= ts_d;
      sh_q    <= sh_d;
      tcnt_q  <= tcnt_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
`ifdef SPLIT_TARGET_PARITY_EN
      dec_q   <= dec_d;
      rw_q    <= rw_d;
      perr_q  <= perr_d;
      tpar_q  <= tpar_d;
`endif
    end
  end

endmodule

// File: tb/tb_split_target_port_gen2.sv
// Scoreboard bench for split_target_port_gen2: queued commands and bit stream.
module tb_split_target_port_gen2;

`ifdef SPLIT_TARGET_PARITY_EN
  localparam int AW = 12;
  localparam int DW = 16;
`else
  localparam int AW = 16;
  localparam int DW = 8;
`endif
  localparam logic [31:0] AM = 32'((64'd1 << AW) - 64'd1);
  localparam logic [31:0] DM = 32'((64'd1 << DW) - 64'd1);

  logic clk = 0;
  logic rst_n;
  logic bus_data_in, bus_data_in_valid, bus_mode, bus_rw, decoder_valid;
  logic bus_data_out, bus_data_out_valid;
  logic [AW-1:0] target_addr_in;
  logic [DW-1:0] target_data_in;
  logic target_cmd_write, target_cmd_valid, target_cmd_ready;
  logic [DW-1:0] target_data_out;
  logic target_data_out_valid, target_data_out_ready;
  logic tx_busy, parity_err;
  logic split_req, arbiter_grant, target_split_ack;
  logic arbiter_split_req, split_grant, bus_split_ack;

  split_target_port_gen2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TX_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_data_in(bus_data_in), .bus_data_in_valid(bus_data_in_valid),
    .bus_mode(bus_mode), .bus_rw(bus_rw), .decoder_valid(decoder_valid),
    .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid),
    .target_addr_in(target_addr_in), .target_data_in(target_data_in),
    .target_cmd_write(target_cmd_write), .target_cmd_valid(target_cmd_valid),
    .target_cmd_ready(target_cmd_ready),
    .target_data_out(target_data_out),
    .target_data_out_valid(target_data_out_valid),
    .target_data_out_ready(target_data_out_ready),
    .tx_busy(tx_busy), .parity_err(parity_err),
    .split_req(split_req), .arbiter_grant(arbiter_grant),
    .target_split_ack(target_split_ack),
    .arbiter_split_req(arbiter_split_req), .split_grant(split_grant),
    .bus_split_ack(bus_split_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
  } cmd_t;

  cmd_t       cq[$];
  logic [1:0] txq[$];
  bit         tx_act = 0;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && target_cmd_valid && target_cmd_ready) begin
      if (cq.size() == 0) begin
        chk("unexpected cmd addr", {16'hdead, 16'(target_addr_in)}, 32'h0);
      end else begin
        cmd_t e;
        e = cq.pop_front();
        chk("cmd addr", 32'(target_addr_in), e.a);
        chk("cmd data", 32'(target_data_in), e.d);
        chk("cmd write", 32'(target_cmd_write), 32'(e.w));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (!tx_act && bus_data_out_valid) begin
        if (txq.size() == 0) chk("unexpected tx bit", 1, 0);
        else tx_act = 1;
      end
      if (tx_act) begin
        logic [1:0] e;
        e = txq.pop_front();
        chk("tx valid", 32'(bus_data_out_valid), 32'(e[1]));
        if (e[1]) chk("tx bit", 32'(bus_data_out), 32'(e[0]));
        if (txq.size() == 0) tx_act = 0;
      end
    end
  end

  task automatic send_bit(input logic b, input logic m);
    bus_data_in = b;
    bus_mode = m;
    bus_data_in_valid = 1;
    @(posedge clk); #1;
    bus_data_in_valid = 0;
  endtask

  task automatic send_addr(input logic [31:0] a, input logic dv,
                           input logic rw);
    decoder_valid = dv;
    bus_rw = rw;
    for (int i = 0; i < AW; i++) send_bit(a[i], 0);
`ifdef SPLIT_TARGET_PARITY_EN
    send_bit(^(a & AM), 0);
`endif
  endtask

  task automatic send_data(input logic [31:0] d, input logic flip);
    for (int i = 0; i < DW; i++) send_bit(d[i], 1);
`ifdef SPLIT_TARGET_PARITY_EN
    send_bit((^(d & DM)) ^ flip, 1);
`else
    if (flip) chk("flip without parity", 0, 0);
`endif
  endtask

  task automatic exp_word(input logic [31:0] w, input bit gap,
                          input int nb);
    if (gap) txq.push_back(2'b00);
    for (int i = 0; i < nb; i++) txq.push_back({1'b1, w[i]});
`ifdef SPLIT_TARGET_PARITY_EN
    if (nb == DW) txq.push_back({1'b1, ^(w & DM)});
`endif
  endtask

  task automatic push_word(input logic [31:0] w, input bit gap,
                           input int nb);
    int n = 0;
    target_data_out = DW'(w);
    target_data_out_valid = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!target_data_out_ready && n < 300);
    chk("push ready", 32'(target_data_out_ready), 1);
    @(posedge clk); #1;
    exp_word(w, gap, nb);
    target_data_out_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (tx_busy && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tx idle", 32'(tx_busy), 0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 0;
    bus_data_in = 0; bus_data_in_valid = 0; bus_mode = 0;
    bus_rw = 0; decoder_valid = 0; target_cmd_ready = 1;
    target_data_out = '0; target_data_out_valid = 0;
    split_req = 0; arbiter_grant = 0; target_split_ack = 0;
    cycles(3);
    chk("rst out valid", 32'(bus_data_out_valid), 0);
    chk("rst cmd valid", 32'(target_cmd_valid), 0);
    chk("rst out ready", 32'(target_data_out_ready), 1);
    chk("rst tx busy", 32'(tx_busy), 0);
    chk("rst parity err", 32'(parity_err), 0);
    rst_n = 1;
    cycles(1);

    split_req = 1; arbiter_grant = 0; target_split_ack = 1;
    #1;
    chk("sb split req", 32'(arbiter_split_req), 1);
    chk("sb grant", 32'(split_grant), 0);
    chk("sb ack", 32'(bus_split_ack), 1);
    split_req = 0; arbiter_grant = 1; target_split_ack = 0;
    #1;
    chk("sb split req 2", 32'(arbiter_split_req), 0);
    chk("sb grant 2", 32'(split_grant), 1);
    chk("sb ack 2", 32'(bus_split_ack), 0);
    cycles(1);

    target_cmd_ready = 0;
    cq.push_back('{32'hA5C3 & AM, 32'h5A & DM, 1'b1});
    send_addr(32'hA5C3, 1, 1);
    send_data(32'h5A, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold valid", 32'(target_cmd_valid), 1);
      chk("hold addr", 32'(target_addr_in), 32'hA5C3 & AM);
      chk("hold data", 32'(target_data_in), 32'h5A);
    end
    @(posedge clk); #1;
    target_cmd_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("valid cleared", 32'(target_cmd_valid), 0);
    cycles(1);

    send_addr(32'h1234, 0, 0);
    cycles(3);
    chk("miss no cmd", 32'(target_cmd_valid), 0);
    cq.push_back('{32'h0042, 32'h0, 1'b0});
    send_addr(32'h0042, 1, 0);
    cycles(3);
    chk("read consumed", 32'(cq.size()), 0);

    send_addr(32'h1111, 1, 1);
    send_bit(1, 1); send_bit(0, 1); send_bit(1, 1);
    cq.push_back('{32'h0B0D & AM, 32'h0, 1'b0});
    send_addr(32'h0B0D, 1, 0);
    cycles(3);
    chk("abort consumed", 32'(cq.size()), 0);

    push_word(32'h01, 0, DW);
    push_word(32'h02, 1, DW);
    push_word(32'h03, 1, DW);
    push_word(32'h04, 1, DW);
    chk("ready before full", 32'(target_data_out_ready), 1);
    push_word(32'h05, 1, DW);
    chk("ready when full", 32'(target_data_out_ready), 0);
    push_word(32'h06, 1, DW);
    wait_idle();
    cycles(2);
    chk("stream drained", 32'(txq.size()), 0);

    push_word(32'h3C, 0, DW);
    n = 0;
    decoder_valid = 1; bus_rw = 0;
    while (tx_busy && n < 60) begin
      send_bit(1, 0);
      n++;
    end
    chk("hd bits sent", 32'(n > 5), 1);
    cycles(2);
    cq.push_back('{32'h0077, 32'h0, 1'b0});
    send_addr(32'h0077, 1, 0);
    cycles(3);
    chk("hd consumed", 32'(cq.size()), 0);

    target_cmd_ready = 0;
    send_addr(32'h0099, 1, 0);
    chk("hold pre-rst", 32'(target_cmd_valid), 1);
    #2 rst_n = 0;
    #1 chk("rst in hold", 32'(target_cmd_valid), 0);
    cycles(1);
    rst_n = 1;
    target_cmd_ready = 1;
    cycles(2);

    push_word(32'hFF, 0, 3);
    chk("lat push", 32'(bus_data_out_valid), 0);
    cycles(1);
    chk("lat load", 32'(bus_data_out_valid), 0);
    cycles(1);
    chk("lat first bit", 32'(bus_data_out_valid), 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst tx valid", 32'(bus_data_out_valid), 0);
    chk("rst tx busy mid", 32'(tx_busy), 0);
    chk("rst ready mid", 32'(target_data_out_ready), 1);
    cycles(3);
    rst_n = 1;
    cycles(20);
    chk("no bits after rst", 32'(bus_data_out_valid), 0);

`ifdef SPLIT_TARGET_PARITY_EN
    send_addr(32'h5C3, 1, 1);
    send_data(32'hBEEF, 1);
    chk("perr pulse", 32'(parity_err), 1);
    cycles(1);
    chk("perr clear", 32'(parity_err), 0);
    chk("perr no cmd", 32'(target_cmd_valid), 0);
    cq.push_back('{32'h5C3, 32'hBEEF, 1'b1});
    send_addr(32'h5C3, 1, 1);
    send_data(32'hBEEF, 0);
    chk("par ok no err", 32'(parity_err), 0);
    cycles(3);
    chk("par consumed", 32'(cq.size()), 0);
`endif

    cycles(5);
    chk("cmd queue empty", 32'(cq.size()), 0);
    chk("tx queue empty", 32'(txq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
